// File: rtl/simon_key_schedule.sv
// SIMON key schedule: loads an M-word master key and streams T round keys
// over a valid/ready handshake, expanding one new key word per transfer.
module simon_key_schedule #(
  parameter int unsigned N  = 16,
  parameter int unsigned M  = 4,
  parameter int unsigned T  = 32,
  parameter int unsigned Cb = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [M*N-1:0] key_in,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [N-1:0]   rk_out,
  output logic [Cb-1:0]  rk_index,
  output logic           rk_last
);

  localparam int unsigned ZW = 6;
  localparam logic [61:0] Z =
    62'b01100111000011010100100010111110110011100001101010010001011111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_d;
  logic [N-1:0]   w [M];
  logic [Cb-1:0]  idx, idx_d;
  logic [ZW-1:0]  zi;
  logic           load, shift;
  logic [N-1:0]   rot3, mix, tmp, f_word;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and handshake decode
  always_comb begin
    state_d = state;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          shift = 1'b1;
          if (idx == Cb'(T - 1)) state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    idx_d = idx;
    if (load)       idx_d = '0;
    else if (shift) idx_d = idx + Cb'(1);
  end

  // Key-expansion function over the current window
  always_comb begin
    rot3   = {w[M-1][2:0], w[M-1][N-1:3]};
    mix    = (M == 4) ? (rot3 ^ w[1]) : rot3;
    tmp    = mix ^ {mix[0], mix[N-1:1]};
    f_word = ~w[0] ^ tmp ^ N'(Z[zi]) ^ N'(3);
  end

  // Window, counters and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < int'(M); j++) w[j] <= '0;
      idx       <= '0;
      zi        <= '0;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
    end else begin
      if (load) begin
        for (int j = 0; j < int'(M); j++) w[j] <= key_in[j*N +: N];
        zi <= '0;
      end else if (shift) begin
        for (int j = 0; j < int'(M) - 1; j++) w[j] <= w[j+1];
        w[M-1] <= f_word;
        zi     <= (zi == ZW'(61)) ? '0 : zi + ZW'(1);
      end
      idx       <= idx_d;
      key_ready <= (state_d == IDLE);
      rk_valid  <= (state_d == RUN);
      rk_last   <= (state_d == RUN) && (idx_d == Cb'(T - 1));
    end
  end

  assign rk_out   = w[0];
  assign rk_index = idx;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Scoreboard bench for simon_key_schedule: a SIMON32/64 array-based model
// fills the expected queue; a negedge monitor pops and compares transfers.
module tb_simon_key_schedule;

  localparam int unsigned N  = 16;
  localparam int unsigned M  = 4;
  localparam int unsigned T  = 32;
  localparam int unsigned CB = 5;
  localparam logic [61:0] ZSEQ =
    62'b01100111000011010100100010111110110011100001101010010001011111;
  localparam logic [95:0] KAT =
    {16'hB649, 16'h71C3, 16'h1918, 16'h1110, 16'h0908, 16'h0100};
  localparam logic [63:0] K0 = 64'h1918_1110_0908_0100;

  logic           clk = 1'b0;
  logic           rst, key_valid, rk_ready;
  logic           key_ready, rk_valid, rk_last;
  logic [M*N-1:0] key_in;
  logic [N-1:0]   rk_out;
  logic [CB-1:0]  rk_index;

  always #5 clk = ~clk;

  simon_key_schedule #(.N(N), .M(M), .T(T), .Cb(CB)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
    .rk_index(rk_index), .rk_last(rk_last)
  );

  typedef struct {
    logic [N-1:0]  key;
    logic [CB-1:0] idx;
    logic          last;
    bit            has_kat;
    logic [N-1:0]  kat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input int s);
    return (x >> s) | (x << (N - s));
  endfunction

  // Whole-schedule reference: k[i+M] from k[i], k[i+1], k[i+M-1] and z bit i
  task automatic push_schedule(input logic [63:0] key, input bit golden);
    logic [N-1:0] k [T+M];
    logic [N-1:0] tmp;
    exp_t e;
    for (int i = 0; i < int'(M); i++) k[i] = key[N*i +: N];
    for (int i = 0; i < int'(T) - int'(M); i++) begin
      tmp = rotr(k[i+M-1], 3);
      if (M == 4) tmp = tmp ^ k[i+1];
      tmp = tmp ^ rotr(tmp, 1);
      k[i+M] = ~k[i] ^ tmp ^ N'(ZSEQ[i % 62]) ^ N'(3);
    end
    for (int i = 0; i < int'(T); i++) begin
      e.key     = k[i];
      e.idx     = CB'(i);
      e.last    = (i == int'(T) - 1);
      e.has_kat = golden && (i < 6);
      e.kat     = (i < 6) ? KAT[N*i +: N] : '0;
      sb.push_back(e);
    end
  endtask

  // Monitor: compares every transfer and checks stall/idle behaviour
  exp_t          m_e;
  logic [N-1:0]  hold_out;
  logic [CB-1:0] hold_idx;
  logic          hold_last;
  bit            stall_prev = 1'b0;
  bit            last_seen  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      last_seen  = 1'b0;
    end else begin
      if (last_seen) begin
        check("idle_rk_valid", 64'(rk_valid), 64'(0));
        check("idle_key_ready", 64'(key_ready), 64'(1));
        last_seen = 1'b0;
      end
      if (stall_prev) begin
        check("stall_valid", 64'(rk_valid), 64'(1));
        check("stall_rk_out", 64'(rk_out), 64'(hold_out));
        check("stall_rk_index", 64'(rk_index), 64'(hold_idx));
        check("stall_rk_last", 64'(rk_last), 64'(hold_last));
      end
      if (rk_valid && rk_ready) begin
        if (sb.size() == 0) begin
          fail_now("sb_underflow");
        end else begin
          m_e = sb.pop_front();
          check("rk_out", 64'(rk_out), 64'(m_e.key));
          check("rk_index", 64'(rk_index), 64'(m_e.idx));
          check("rk_last", 64'(rk_last), 64'(m_e.last));
          if (m_e.has_kat) check("kat_rk_out", 64'(rk_out), 64'(m_e.kat));
          xfer_cnt++;
          if (m_e.last) begin
            done_cnt++;
            last_seen = 1'b1;
          end
        end
      end
      stall_prev = rk_valid && !rk_ready;
      hold_out   = rk_out;
      hold_idx   = rk_index;
      hold_last  = rk_last;
    end
  end

  task automatic load_key(input logic [63:0] k, input bit golden);
    int n = 0;
    @(negedge clk);
    while (!key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) fail_now("load_timeout");
    push_schedule(k, golden);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt <= start && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt <= start) fail_now("done_timeout");
  endtask

  task automatic random_ready_run(input logic [63:0] k, input bit golden);
    int start = done_cnt;
    int stretch = 0;
    int n = 0;
    rk_ready = 1'b0;
    load_key(k, golden);
    while (done_cnt <= start && n < 3000) begin
      @(posedge clk);
      #1;
      if (stretch > 0) begin
        rk_ready = 1'b0;
        stretch--;
      end else if ($urandom_range(0, 7) == 0) begin
        rk_ready = 1'b0;
        stretch  = 4;
      end else begin
        rk_ready = 1'($urandom_range(0, 1));
      end
      n++;
    end
    if (done_cnt <= start) fail_now("random_done_timeout");
    rk_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int n;
    logic [63:0] ka, kb;
    rst = 1'b1; key_valid = 1'b0; rk_ready = 1'b0; key_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_key_ready", 64'(key_ready), 64'(1));
    check("reset_rk_valid", 64'(rk_valid), 64'(0));
    check("reset_rk_last", 64'(rk_last), 64'(0));
    check("reset_rk_out", 64'(rk_out), 64'(0));
    check("reset_rk_index", 64'(rk_index), 64'(0));
    rst = 1'b0;

    // Known-answer key at full rate, with a competing key offered mid-run
    rk_ready = 1'b1;
    start = done_cnt;
    load_key(K0, 1'b1);
    repeat (3) @(posedge clk);
    #1 key_in = {$urandom, $urandom};
    key_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 key_valid = 1'b0;
    wait_done(start);
    repeat (2) @(posedge clk);

    // Random backpressure with stalls, known key then random key
    random_ready_run(K0, 1'b1);
    random_ready_run({$urandom, $urandom}, 1'b0);
    repeat (2) @(posedge clk);

    // Reset after 10 transfers, then reload
    #1 rk_ready = 1'b1;
    start = xfer_cnt;
    load_key(K0, 1'b1);
    n = 0;
    while (xfer_cnt < start + 10 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (xfer_cnt < start + 10) fail_now("xfer10_timeout");
    #1 rst = 1'b1;
    rk_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rk_valid", 64'(rk_valid), 64'(0));
    check("midrst_key_ready", 64'(key_ready), 64'(1));
    check("midrst_rk_index", 64'(rk_index), 64'(0));
    check("midrst_rk_out", 64'(rk_out), 64'(0));
    check("midrst_rk_last", 64'(rk_last), 64'(0));
    rst = 1'b0;
    sb.delete();
    rk_ready = 1'b1;
    start = done_cnt;
    load_key(K0, 1'b1);
    wait_done(start);
    repeat (2) @(posedge clk);

    // Back-to-back master keys with key_valid held high
    ka = {$urandom, $urandom};
    kb = {$urandom, $urandom};
    start = done_cnt;
    load_key(ka, 1'b0);
    key_in    = kb;
    key_valid = 1'b1;
    push_schedule(kb, 1'b0);
    wait_done(start);
    @(negedge clk);
    check("b2b_gap_rk_valid", 64'(rk_valid), 64'(0));
    @(negedge clk);
    check("b2b_accept_valid", 64'(rk_valid), 64'(1));
    check("b2b_accept_index", 64'(rk_index), 64'(0));
    check("b2b_accept_key", 64'(rk_out), 64'(kb[N-1:0]));
    key_valid = 1'b0;
    wait_done(start + 1);

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_key_schedule.md
Name: simon_key_schedule

Overview:
- Sequential SIMON key schedule that sits between master-key load and the round datapath.
- Accepts an M-word master key, holds an M-word sliding window, and generates each new round key from that window using the SIMON key-expansion function.
- Streams round keys k0..k(T-1) to the round function over a valid/ready handshake, one key per accepted transfer.

Parameters:
N, 16, word width in bits
M, 4, key words (2, 3 or 4)
T, 32, number of round keys emitted per master key
Cb, 5, round-index width; 2^Cb >= T required

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
key_valid  in  1  master key offered
key_ready  out  1  block can accept a master key
key_in  in  M*N  master key; key_in[N-1:0] = k0, key_in[2N-1:N] = k1, ..., top word = k(M-1)
rk_valid  out  1  round key on rk_out is valid
rk_ready  in  1  downstream accepts round key
rk_out  out  N  current round key k[idx]
rk_index  out  Cb  idx of rk_out
rk_last  out  1  high with rk_valid when idx == T-1

Behaviour:
- State: window w[0..M-1] of N-bit words (w[0] oldest), idx (Cb bits), zi (6-bit counter, 0..61), FSM {IDLE, RUN}.
- Reset values: state IDLE, key_ready=1, rk_valid=0, rk_last=0, rk_out=0, rk_index=0, window=0, idx=0, zi=0.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid && key_ready: load w[j] = key_in word j, set idx=0 and zi=0, go RUN.
  - First key is presented the next cycle.
- RUN:
  - key_ready=0; key_valid is ignored.
  - rk_valid=1, rk_out=w[0], rk_index=idx, rk_last=(idx==T-1).
- Transfer = rk_valid && rk_ready in RUN:
  - Window shifts: w[j] <= w[j+1] for j < M-1; w[M-1] <= f(w, zi).
  - idx increments.
  - zi increments, wrapping 61 -> 0.
- Function f(w, zi), combinational, N-bit:
  - t = w[M-1] rotated right by 3.
  - If M==4: t ^= w[1].
  - t ^= (t rotated right by 1).
  - f = ~w[0] ^ t ^ zbit ^ 3, where zbit is zero-extended to N bits and 3 is an N-bit constant.
  - zbit = bit zi of Z, with bit 0 = rightmost digit of Z = 62'b01100111000011010100100010111110110011100001101010010001011111.
  - The z-sequence is fixed; selecting other SIMON z-sequences is out of scope.
- Transfer with rk_last=1: go IDLE, rk_valid=0 and key_ready=1 the next cycle. The window update on this transfer is don't-care.
- Stall (rk_valid && !rk_ready): rk_out, rk_index, rk_last, window, idx and zi are all held unchanged. There is no timeout.
- Throughput: one key per cycle while rk_ready is held high. Latency from key acceptance to k0 valid is 1 cycle. IDLE costs 1 cycle between master keys.
- Reset mid-RUN: next cycle is IDLE with all outputs at reset values. The partially emitted schedule is discarded.
- Simultaneous rst with either handshake: rst wins; no load, no shift.
- Output timing: all outputs are registered or decoded from registered state only; there is no combinational path from rk_ready or key_valid to any output.

Test Plan:
- Reset then load key_in=64'h1918_1110_0908_0100 with rk_ready=1 -> the first six keys, with rk_index 0..5, are 0100, 0908, 1110, 1918, 71C3, B649.
- Same key, 32 transfers -> rk_last high only at rk_index=31; the cycle after, rk_valid=0 and key_ready=1. Compare all 32 keys against a software SIMON32/64 model.
- rk_ready toggled randomly (including 5-cycle low stretches) -> key sequence identical to the continuous case; rk_out and rk_index stable throughout each stall.
- key_valid asserted during RUN with a different key -> ignored; the current schedule completes unchanged.
- rst asserted after 10 transfers -> next cycle rk_valid=0, key_ready=1. A reload of the same key then restarts at 0100 with rk_index=0.
- Two master keys back to back (second key_valid held high) -> second key accepted in the IDLE cycle immediately after the first schedule's last transfer. The second schedule starts with zi=0 and matches the model.
